// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative 16-bit shift/rotate unit.
// The operand walks through four barrel stages (1, 2, 4, 8 positions), one stage
// per clock. Each stage applies its shift only if the matching shamt bit is set.
// A start/done handshake frames each operation. result and zero are registered
// and change only when the unit enters DONE.
module shift_sequencer #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [3:0]       shamt,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SW = $clog2(STAGES);
    localparam logic [SW-1:0] LAST_STG = SW'(STAGES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    state_t            state, state_nxt;
    logic              load;
    logic [WIDTH-1:0]  work;
    logic [STAGES-1:0] amt;
    op_t               op_q;
    logic              sign_q;
    logic [SW-1:0]     stg;
    logic [WIDTH-1:0]  stage_out;

    // One barrel stage: shift v by 2**s positions in the direction and with the
    // fill chosen by o. A double-width vector holds the fill bits (zeros, sign
    // copies, or a second copy of v for rotate) so one shift covers all ops.
    function automatic logic [WIDTH-1:0] barrel_stage(
        input logic [WIDTH-1:0] v,
        input logic [SW-1:0]    s,
        input op_t              o,
        input logic             sg
    );
        logic [2*WIDTH-1:0] ext;
        int unsigned        k;
        k   = 32'd1 << s;
        ext = '0;
        case (o)
            OP_SRL:  ext = {{WIDTH{1'b0}}, v} >> k;
            OP_SLL:  ext = {{WIDTH{1'b0}}, v} << k;
            OP_SRA:  ext = {{WIDTH{sg}}, v} >> k;
            OP_ROR:  ext = {v, v} >> k;
            default: ext = {{WIDTH{1'b0}}, v};
        endcase
        return ext[WIDTH-1:0];
    endfunction

    // Current stage output: shift only when this stage's shamt bit is set.
    always_comb begin
        stage_out = work;
        if (amt[stg]) begin
            stage_out = barrel_stage(work, stg, op_q, sign_q);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the operand-load strobe; start is ignored in SHIFT.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (stg == LAST_STG) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on load, step one stage per SHIFT cycle, and
    // publish result/zero from the final stage output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= '0;
            amt    <= '0;
            op_q   <= OP_SRL;
            sign_q <= 1'b0;
            stg    <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else if (load) begin
            work   <= data_in;
            amt    <= shamt;
            op_q   <= op_t'(op);
            sign_q <= data_in[WIDTH-1];
            stg    <= '0;
        end else if (state == SHIFT) begin
            work <= stage_out;
            stg  <= stg + 1'b1;
            if (stg == LAST_STG) begin
                result <= stage_out;
                zero   <= (stage_out == '0);
            end
        end
    end

    // Handshake outputs decode directly from the state register.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    logic [3:0]  shamt;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        zero;

    int pass_cnt = 0;
    int total    = 0;

    shift_sequencer #(.WIDTH(16), .STAGES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .shamt   (shamt),
        .op      (op),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .zero    (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Present one request at a negedge, hold start across the accepting edge E0,
    // then drop start just after E0.
    task automatic launch(input logic [15:0] d, input logic [3:0] s, input logic [1:0] o);
        @(negedge clk);
        data_in = d;
        shamt   = s;
        op      = o;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count rising edges until done is seen (sampled 1 after each edge); -1 if none in 10.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; data_in = '0; shamt = '0; op = '0;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, result, zero} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
            $display("FAIL reset_state: got busy=%b done=%b result=%h zero=%b, required 0 0 0000 1",
                     busy, done, result, zero);
        end else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL idle_after_reset[%0d]: got done=%b busy=%b, required 0 0", i, done, busy);
            end else pass_cnt++;
        end
    endtask

    task automatic test_srl();
        int cyc;
        launch(16'h8001, 4'd1, 2'b00);
        total++;
        if (busy !== 1'b1) $display("FAIL srl_busy: got %b, required 1", busy);
        else pass_cnt++;
        wait_done(cyc);
        total++;
        if (cyc !== 4) $display("FAIL srl_latency: got %0d, required 4", cyc);
        else pass_cnt++;
        total++;
        if (result !== 16'h4000 || zero !== 1'b0 || busy !== 1'b0)
            $display("FAIL srl_result: got %h zero=%b busy=%b, required 4000 0 0", result, zero, busy);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || result !== 16'h4000)
            $display("FAIL srl_done_pulse: got done=%b result=%h, required 0 4000", done, result);
        else pass_cnt++;
    endtask

    task automatic test_ops();
        logic [15:0] vd [7];
        logic [3:0]  vs [7];
        logic [1:0]  vo [7];
        logic [15:0] ve [7];
        int cyc;
        vd[0] = 16'h0001; vs[0] = 4'd15; vo[0] = 2'b01; ve[0] = 16'h8000;
        vd[1] = 16'h8000; vs[1] = 4'd4;  vo[1] = 2'b10; ve[1] = 16'hF800;
        vd[2] = 16'h7FF0; vs[2] = 4'd4;  vo[2] = 2'b10; ve[2] = 16'h07FF;
        vd[3] = 16'h1234; vs[3] = 4'd4;  vo[3] = 2'b11; ve[3] = 16'h4123;
        vd[4] = 16'h0001; vs[4] = 4'd15; vo[4] = 2'b11; ve[4] = 16'h0002;
        vd[5] = 16'hA5A5; vs[5] = 4'd0;  vo[5] = 2'b00; ve[5] = 16'hA5A5;
        vd[6] = 16'hC3C3; vs[6] = 4'd10; vo[6] = 2'b01; ve[6] = 16'h0C00;
        for (int i = 0; i < 7; i++) begin
            launch(vd[i], vs[i], vo[i]);
            wait_done(cyc);
            total++;
            if (cyc !== 4 || result !== ve[i] || zero !== 1'b0)
                $display("FAIL op_vec[%0d]: got cyc=%0d result=%h zero=%b, required 4 %h 0",
                         i, cyc, result, zero, ve[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_zero();
        int cyc;
        launch(16'h0001, 4'd1, 2'b00);
        wait_done(cyc);
        total++;
        if (cyc !== 4 || result !== 16'h0000 || zero !== 1'b1)
            $display("FAIL zero_flag: got cyc=%0d result=%h zero=%b, required 4 0000 1", cyc, result, zero);
        else pass_cnt++;
    endtask

    task automatic test_ignore_start();
        int cyc;
        launch(16'h00F0, 4'd4, 2'b00);
        @(posedge clk);
        @(negedge clk);
        data_in = 16'hFFFF; shamt = 4'd1; op = 2'b01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        total++;
        if (cyc !== 2 || result !== 16'h000F)
            $display("FAIL ignore_start: got cyc=%0d result=%h, required 2 000F", cyc, result);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL ignore_start_idle: got busy=%b done=%b, required 0 0", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        data_in = 16'h1234; shamt = 4'd8; op = 2'b11; start = 1'b1;
        @(posedge clk);
        #1;
        data_in = 16'hF000; shamt = 4'd12; op = 2'b10;
        wait_done(cyc);
        total++;
        if (cyc !== 4 || result !== 16'h3412)
            $display("FAIL b2b_first: got cyc=%0d result=%h, required 4 3412", cyc, result);
        else pass_cnt++;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_accept: got busy=%b done=%b, required 1 0", busy, done);
        else pass_cnt++;
        wait_done(cyc);
        total++;
        if (cyc !== 4 || result !== 16'hFFFF || zero !== 1'b0)
            $display("FAIL b2b_second: got cyc=%0d result=%h zero=%b, required 4 FFFF 0", cyc, result, zero);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        launch(16'h00FF, 4'd4, 2'b01);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || zero !== 1'b1)
            $display("FAIL reset_mid_op: got busy=%b done=%b result=%h zero=%b, required 0 0 0000 1",
                     busy, done, result, zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(cyc);
        total++;
        if (cyc !== -1) $display("FAIL reset_no_done: got done after %0d cycles, required none", cyc);
        else pass_cnt++;
        launch(16'h00FF, 4'd4, 2'b01);
        wait_done(cyc);
        total++;
        if (cyc !== 4 || result !== 16'h0FF0)
            $display("FAIL after_reset_op: got cyc=%0d result=%h, required 4 0FF0", cyc, result);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_srl();
        test_ops();
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle 16-bit shift/rotate unit that walks an operand through four barrel stages (1, 2, 4, 8 bits), one stage per clock, under a start/done handshake. It sits in the datapath between the register-file read ports and the ALU result mux. It replaces a single-cycle combinational shifter tree with a registered, iterative one. Each stage reuses the same 1/2/4/8-position shift structure as the existing barrel stages, with direction and fill selected per operation.

## Interface
- WIDTH, 16: operand width; fixed at 16, other values unsupported.
- STAGES, 4: number of barrel stages (shift amounts 1, 2, 4, 8); must satisfy 2**STAGES == WIDTH.
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only when the block is able to accept.
- data_in  input  16  operand, sampled with start.
- shamt  input  4  shift amount 0–15, sampled with start.
- op  input  2  operation, sampled with start:
  - 00: SRL, logical right, zero fill.
  - 01: SLL, logical left, zero fill.
  - 10: SRA, arithmetic right, fill with bit 15 of data_in.
  - 11: ROR, rotate right.
- busy  output  1  high while stages are being applied.
- done  output  1  one-cycle pulse; result is valid from this cycle.
- result  output  16  last completed result, held until the next completion.
- zero  output  1  high when result == 16'h0000; registered alongside result.

## Operation
- States: IDLE, SHIFT, DONE.
- Internal registers:
  - work[15:0], the working operand.
  - amt[3:0], op_q[1:0], sign_q.
  - stage counter stg[1:0].
- IDLE or DONE with start=1:
  - load work=data_in, amt=shamt, op_q=op, sign_q=data_in[15], stg=0.
  - go to SHIFT.
- SHIFT, each cycle:
  - if amt[stg]=1, shift work by 2**stg per op_q; otherwise hold work.
  - SRL fills vacated MSBs with 0. SLL fills vacated LSBs with 0. SRA fills vacated MSBs with sign_q. ROR moves LSBs shifted out into the MSBs.
  - stg increments. When stg==3, go to DONE and load result and zero from the stage-3 output.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 here begins a new operation (back-to-back); otherwise return to IDLE.
- start while in SHIFT is ignored; no queuing and no error flag.
- shamt=0 still takes the full latency and returns data_in unchanged.
- result and zero change only on DONE entry. They are stable throughout busy.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, busy=0, done=0, result=16'h0000, zero=1.
  - work, amt, stg, op_q and sign_q all clear to 0.
- Reset mid-operation aborts immediately: no done pulse, result returns to 0.
- Start accepted at rising edge E0: busy=1 from E0 to E4.
- Stages 1/2/4/8 are applied at edges E1, E2, E3, E4.
- done=1 and result valid in the cycle after E4, i.e. 4 cycles after acceptance.
- Throughput is one operation per 5 cycles with back-to-back start in DONE.
- busy and done are never high together.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 asynchronously mid-cycle → busy=0, done=0, result=0x0000, zero=1 immediately. Release, idle 3 cycles → no done.
- SRL 0x8001 by 1 → done exactly 4 cycles after start, result=0x4000, zero=0. SLL 0x0001 by 15 → result=0x8000.
- SRA 0x8000 by 4 → 0xF800. SRA 0x7FF0 by 4 → 0x07FF. ROR 0x1234 by 4 → 0x4123. ROR 0x0001 by 15 → 0x0002.
- shamt=0 on 0xA5A5 → 0xA5A5 after full latency. SRL 0x0001 by 1 → 0x0000 with zero=1.
- start pulsed during SHIFT with different data → ignored, original result delivered. start held high in DONE → second op accepted, done cycles 5 apart.
- Reset asserted at E2 of an op → no done pulse. Next op after release completes normally.
